// File: rtl/mem_access_unit.sv
// Load/store initiator for the pipelined CPU data memory: valid/ready request in,
// single-cycle r_mem/w_mem strobe out, registered response. Option: MEM_ACCESS_ADDR_CHECK_EN.
module mem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int ADDR_LSB = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              r_mem,
    output logic              w_mem,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W:0]   mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

    state_t r_state;
    logic   w_addr_ok;
    logic   w_unused_msb;

    // The memory's extra status bit carries nothing this unit needs.
    assign w_unused_msb = mem_rdata[DATA_W];

`ifdef MEM_ACCESS_ADDR_CHECK_EN
    logic r_err;

    assign w_addr_ok = (req_addr == req_wdata[ADDR_LSB+ADDR_W-1:ADDR_LSB]);
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && req_valid) begin
            r_err <= req_we && !w_addr_ok;
        end
    end
`else
    assign w_addr_ok = 1'b1;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            r_mem     <= 1'b0;
            w_mem     <= 1'b0;
            mem_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        rsp_rdata <= '0;
                        if (req_we) begin
                            // A rejected store still walks through WR_ISSUE so its response timing is unchanged.
                            r_state  <= WR_ISSUE;
                            w_mem    <= w_addr_ok;
                            mem_data <= req_wdata;
                        end else begin
                            r_state  <= RD_ISSUE;
                            r_mem    <= 1'b1;
                            mem_data <= DATA_W'(req_addr) << ADDR_LSB;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_mem    <= 1'b0;
                    mem_data <= '0;
                    r_state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_rdata <= mem_rdata[DATA_W-1:0];
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                WR_ISSUE: begin
                    w_mem     <= 1'b0;
                    mem_data  <= '0;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, back-to-back and reset
// sequences, then random loads/stores against a word-array reference model.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [10:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        r_mem;
    logic        w_mem;
    logic [31:0] mem_data;
    logic [32:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:2047];
    logic [31:0] ref_mem [0:2047];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .r_mem     (r_mem),
        .w_mem     (w_mem),
        .mem_data  (mem_data),
        .mem_rdata (mem_rdata)
    );

    // Data memory with registered read; the top status bit is set to show it is ignored.
    initial begin
        for (int i = 0; i < 2048; i++) mem_arr[i] = 32'hA500_0000 | i;
        forever begin
            @(posedge clk);
            if (w_mem) mem_arr[mem_data[21:11]] <= mem_data;
            if (r_mem) mem_rdata <= {1'b1, mem_arr[mem_data[21:11]]};
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) check("strobe_excl", {63'd0, r_mem & w_mem}, 64'd0);
    end

    // One complete transaction started from IDLE; dly = RESP cycles with rsp_ready low.
    task automatic txn(input bit we, input logic [10:0] addr, input logic [31:0] wdata,
                       input int dly, input logic [31:0] exp_rdata, input bit exp_err);
        int n;
        int lat;
        int strobes;
        logic [31:0] exp_bus;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        rsp_ready = (dly == 0);
        exp_bus = we ? wdata : (32'(addr) << 11);
        @(posedge clk);
        lat = 0; strobes = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                check("busy_ready", {63'd0, req_ready}, 64'd0);
                check("issue_bus", {32'd0, mem_data}, {32'd0, exp_bus});
            end
            if (c == 2) check("bus_idle", {32'd0, mem_data}, 64'd0);
            if (r_mem || w_mem) begin
                strobes++;
                check("strobe_kind", {62'd0, r_mem, w_mem}, we ? 64'd1 : 64'd2);
            end
            if (rsp_valid) lat = c;
        end
        check("rsp_latency", 64'(lat), we ? 64'd2 : 64'd3);
        check("strobe_count", 64'(strobes), (we && exp_err) ? 64'd0 : 64'd1);
        check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
        check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            check("hold", {29'd0, rsp_valid, req_ready, r_mem | w_mem, rsp_rdata}, {32'd4, exp_rdata});
            if (d == dly - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("retire", {62'd0, rsp_valid, req_ready}, 64'd1);
        if (we && !exp_err) ref_mem[wdata[21:11]] = wdata;
    endtask

    typedef struct {
        bit          we;
        logic [10:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit          we_q [3];
        logic [10:0] ad_q [3];
        logic [31:0] wd_q [3];
        logic [31:0] exp_q [3];
        logic [31:0] got [3];
        int          acc [3];
        int          idx, nrsp;
        bit          pend;

        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'hA500_0000 | i;
        tbl[0] = '{1'b1, 11'd5, 32'h0000_2800, 0, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 11'd5, 32'h0,         0, 32'h0000_2800, 1'b0};
        tbl[2] = '{1'b0, 11'd5, 32'h0,         5, 32'h0000_2800, 1'b0};
        tbl[3] = '{1'b1, 11'd3, 32'h0000_2800, 0, 32'h0, CHK};
        tbl[4] = '{1'b0, 11'd3, 32'h0,         0, 32'hA500_0003, 1'b0};
        tbl[5] = '{1'b0, 11'd6, 32'h0,         1, 32'hA500_0006, 1'b0};

        #12;
        check("rst_outputs", {58'd0, req_ready, rsp_valid, r_mem, w_mem, rsp_err, |mem_data}, 64'h20);
        check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 6; i++)
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dly, tbl[i].exp_rdata, tbl[i].exp_err);

        // Back-to-back load, store, load with req_valid held high.
        we_q = '{1'b0, 1'b1, 1'b0};
        ad_q = '{11'd2, 11'd2, 11'd2};
        wd_q = '{32'h0, (32'd2 << 11) | 32'h77, 32'h0};
        exp_q = '{ref_mem[2], 32'h0, (32'd2 << 11) | 32'h77};
        idx = 0; nrsp = 0; pend = 0;
        acc = '{0, 0, 0};
        got = '{32'h0, 32'h0, 32'h0};
        @(negedge clk);
        req_valid = 1'b1; req_we = we_q[0]; req_addr = ad_q[0]; req_wdata = wd_q[0]; rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (req_ready && req_valid && idx < 3) begin acc[idx] = c; pend = 1'b1; end
            @(negedge clk);
            if (rsp_valid && nrsp < 3) begin got[nrsp] = rsp_rdata; nrsp++; end
            if (pend) begin
                pend = 1'b0; idx++;
                if (idx < 3) begin req_we = we_q[idx]; req_addr = ad_q[idx]; req_wdata = wd_q[idx]; end
                else req_valid = 1'b0;
            end
        end
        ref_mem[2] = wd_q[1];
        check("b2b_accepts", 64'(idx), 64'd3);
        check("b2b_load_gap", 64'(acc[1] - acc[0]), 64'd4);
        check("b2b_store_gap", 64'(acc[2] - acc[1]), 64'd3);
        check("b2b_nrsp", 64'(nrsp), 64'd3);
        for (int i = 0; i < 3; i++) check("b2b_order", {32'd0, got[i]}, {32'd0, exp_q[i]});

        // Reset asserted during RD_WAIT, away from any clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd7;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        check("rw_rd_issue", {63'd0, r_mem}, 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_rst", {58'd0, req_ready, rsp_valid, r_mem, w_mem, rsp_err, |mem_data}, 64'h20);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd9; req_wdata = (32'd9 << 11) | 32'h5A;
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        check("post_rst_accept", {62'd0, w_mem, rsp_valid}, 64'd2);
        @(negedge clk);
        check("post_rst_rsp", {31'd0, rsp_valid, rsp_rdata}, {32'd1, 32'd0});
        ref_mem[9] = (32'd9 << 11) | 32'h5A;
        @(negedge clk);

        // Random traffic against the reference array.
        for (int i = 0; i < 40; i++) begin
            bit          we;
            logic [10:0] addr, tgt;
            logic [31:0] wd, er;
            bit          ee;
            we = 1'($urandom_range(0, 1));
            addr = 11'($urandom_range(0, 15));
            wd = $urandom;
            tgt = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 15)) : addr;
            wd[21:11] = tgt;
            ee = we && CHK && (tgt != addr);
            er = we ? 32'h0 : ref_mem[addr];
            txn(we, addr, wd, $urandom_range(0, 3), er, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
